// File: rtl/fpc_rc_demux.sv
// fpc_rc_demux: issues read tags per channel, reorders tagged 64-byte completions
// in a per-channel buffer, and drains each channel in request order. Macro: HIFIFO_RC_ERRCHK_EN.
module fpc_rc_demux #(
  parameter logic [3:0] ENABLE = 4'b0011
) (
  input  logic         clock,
  input  logic         reset,
  output logic [3:0]   o_tag_valid,
  output logic [11:0]  o_tag_low,
  input  logic [3:0]   i_tag_ready,
  input  logic         i_rc_valid,
  input  logic [7:0]   i_rc_tag,
  input  logic [2:0]   i_rc_index,
  input  logic [63:0]  i_rc_data,
  output logic         o_rc_error,
  output logic [3:0]   o_d_valid,
  output logic [255:0] o_d_data,
  input  logic [3:0]   i_d_ready
);

  logic [1:0] w_ch;
  logic [2:0] w_low;
  logic       w_fmt;
  logic [3:0] w_acc_ch;

  assign w_ch  = i_rc_tag[5:4];
  assign w_low = i_rc_tag[2:0];
  assign w_fmt = i_rc_valid && (i_rc_tag[7:6] == 2'b00) && !i_rc_tag[3];

  for (genvar g = 0; g < 4; g++) begin : g_ch
    if (ENABLE[g]) begin : g_on
      logic [63:0] r_mem [64];
      logic [7:0]  r_mask [8];
      logic [3:0]  r_issue;
      logic [3:0]  r_head;
      logic [3:0]  r_rdp;
      logic [2:0]  r_rdi;
      logic        r_dv;
      logic        r_last;
      logic [63:0] r_dd;
      logic [3:0]  w_outs;
      logic        w_tv;
      logic        w_issue;
      logic        w_hit;
      logic        w_acc;
      logic        w_rd;
      logic        w_retire;

      assign w_outs  = r_issue - r_head;
      assign w_tv    = !reset && (w_outs != 4'd8);
      assign w_issue = w_tv && i_tag_ready[g];
      assign w_hit   = w_fmt && (w_ch == 2'(g));

`ifdef HIFIFO_RC_ERRCHK_EN
      logic w_inwin;
      logic w_dup;
      assign w_inwin = ({1'b0, 3'(w_low - r_head[2:0])} < w_outs);
      assign w_dup   = r_mask[w_low][i_rc_index];
      assign w_acc   = w_hit && w_inwin && !w_dup;
`else
      assign w_acc   = w_hit;
`endif

      // Read pointer runs up to one block ahead of head so the next block
      // can be fetched while the head's last word is still in the output register.
      assign w_rd     = (r_rdp != r_issue) && (r_mask[r_rdp[2:0]] == 8'hFF) &&
                        (!r_dv || i_d_ready[g]);
      assign w_retire = r_dv && i_d_ready[g] && r_last;

      always_ff @(posedge clock) begin
        if (w_acc) r_mem[{w_low, i_rc_index}] <= i_rc_data;
      end

      always_ff @(posedge clock) begin
        if (reset) begin
          r_issue <= '0;
          r_head  <= '0;
          r_rdp   <= '0;
          r_rdi   <= '0;
          r_dv    <= 1'b0;
          r_last  <= 1'b0;
          r_dd    <= '0;
          for (int unsigned i = 0; i < 8; i++) r_mask[i] <= '0;
        end else begin
          if (w_issue)  r_issue <= r_issue + 4'd1;
          if (w_retire) begin
            r_head              <= r_head + 4'd1;
            r_mask[r_head[2:0]] <= '0;
          end
          if (w_acc) r_mask[w_low][i_rc_index] <= 1'b1;
          if (w_rd) begin
            r_dd   <= r_mem[{r_rdp[2:0], r_rdi}];
            r_dv   <= 1'b1;
            r_last <= (r_rdi == 3'd7);
            r_rdi  <= r_rdi + 3'd1;
            if (r_rdi == 3'd7) r_rdp <= r_rdp + 4'd1;
          end else if (i_d_ready[g]) begin
            r_dv <= 1'b0;
          end
        end
      end

      assign o_tag_valid[g]      = w_tv;
      assign o_tag_low[3*g +: 3] = r_issue[2:0];
      assign o_d_valid[g]        = r_dv;
      assign o_d_data[64*g +: 64] = r_dd;
      assign w_acc_ch[g]         = w_acc;
    end else begin : g_off
      logic w_unused_in;
      assign w_unused_in          = i_tag_ready[g] | i_d_ready[g];
      assign o_tag_valid[g]       = 1'b0;
      assign o_tag_low[3*g +: 3]  = '0;
      assign o_d_valid[g]         = 1'b0;
      assign o_d_data[64*g +: 64] = '0;
      assign w_acc_ch[g]          = 1'b0;
    end
  end

`ifdef HIFIFO_RC_ERRCHK_EN
  logic r_err;
  always_ff @(posedge clock) begin
    if (reset) r_err <= 1'b0;
    else       r_err <= i_rc_valid && !(|w_acc_ch);
  end
  assign o_rc_error = r_err;
`else
  logic w_unused_acc;
  assign w_unused_acc = |w_acc_ch;
  assign o_rc_error   = 1'b0;
`endif

endmodule

// File: tb/tb_fpc_rc_demux.sv
// Directed bench for fpc_rc_demux: tag issue, reordering, stalls, drops and reset.
module tb_fpc_rc_demux;
  logic         clock = 1'b0;
  logic         reset;
  logic [3:0]   tag_valid;
  logic [11:0]  tag_low;
  logic [3:0]   tag_ready;
  logic         rc_valid;
  logic [7:0]   rc_tag;
  logic [2:0]   rc_index;
  logic [63:0]  rc_data;
  logic         rc_error;
  logic [3:0]   d_valid;
  logic [255:0] d_data;
  logic [3:0]   d_ready;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  fpc_rc_demux #(.ENABLE(4'b0011)) dut (
    .clock(clock), .reset(reset),
    .o_tag_valid(tag_valid), .o_tag_low(tag_low), .i_tag_ready(tag_ready),
    .i_rc_valid(rc_valid), .i_rc_tag(rc_tag), .i_rc_index(rc_index), .i_rc_data(rc_data),
    .o_rc_error(rc_error), .o_d_valid(d_valid), .o_d_data(d_data), .i_d_ready(d_ready)
  );

  function automatic logic [63:0] wd(input logic [7:0] t, input logic [2:0] i);
    return {40'hD47A000000, t, 13'h0, i};
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [7:0] t, input logic [2:0] i, input logic [63:0] d);
    rc_valid = 1'b1; rc_tag = t; rc_index = i; rc_data = d;
    step();
    rc_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1; tag_ready = '0; rc_valid = 1'b0; rc_tag = '0; rc_index = '0;
    rc_data = '0; d_ready = 4'b1111;
    step(); step();
    reset = 1'b0;
  endtask

  logic [63:0] held;
  logic        stall;
  logic        r;
  int          cnt0, cnt1;

  initial begin
    // reset state
    reset = 1'b1; tag_ready = '0; rc_valid = 1'b0; rc_tag = '0; rc_index = '0;
    rc_data = '0; d_ready = 4'b1111;
    step(); step();
    chk("rst_tag_valid", 256'(tag_valid), 256'(4'b0000));
    chk("rst_d_valid",   256'(d_valid),   256'(4'b0000));
    chk("rst_d_data",    d_data,          256'h0);
    chk("rst_rc_error",  256'(rc_error),  256'(1'b0));
    reset = 1'b0;
    step();
    chk("post_rst_tag_valid", 256'(tag_valid), 256'(4'b0011));
    chk("post_rst_tag_low",   256'(tag_low),   256'(12'h000));

    // eight tag issues on ch0 exhaust the tag space
    for (int k = 0; k < 8; k++) begin
      chk("issue_low",   256'(tag_low[2:0]), 256'(k[2:0]));
      chk("issue_valid", 256'(tag_valid[0]), 256'(1'b1));
      tag_ready = 4'b0001;
      step();
    end
    chk("full_tag_valid", 256'(tag_valid), 256'(4'b0010));
    step();
    tag_ready = '0;
    chk("full_no_issue_low", 256'(tag_low[2:0]), 256'(3'd0));

    // out-of-order blocks: tag 1 arrives before tag 0
    do_reset();
    tag_ready = 4'b0001; step(); step(); tag_ready = '0;
    chk("two_out_low",   256'(tag_low[2:0]), 256'(3'd2));
    chk("two_out_valid", 256'(tag_valid[0]), 256'(1'b1));
    for (int i = 0; i < 8; i++) send(8'h01, 3'(i), wd(8'h01, 3'(i)));
    chk("ooo_held", 256'(d_valid[0]), 256'(1'b0));
    for (int i = 0; i < 8; i++) send(8'h00, 3'(i), wd(8'h00, 3'(i)));
    chk("lat_n1_no_valid", 256'(d_valid[0]), 256'(1'b0));
    step();
    chk("lat_n2_valid", 256'(d_valid[0]), 256'(1'b1));
    chk("ooo_w0", d_data[63:0], 256'(wd(8'h00, 3'd0)));
    for (int j = 1; j < 16; j++) begin
      step();
      chk("ooo_stream_v", 256'(d_valid[0]), 256'(1'b1));
      chk("ooo_stream_d", d_data[63:0], 256'(wd(8'(j / 8), 3'(j % 8))));
    end
    step();
    chk("ooo_drained", 256'(d_valid), 256'(4'b0000));

    // reverse index order within a block
    tag_ready = 4'b0001; step(); tag_ready = '0;
    for (int i = 7; i >= 0; i--) send(8'h02, 3'(i), wd(8'h02, 3'(i)));
    step();
    for (int j = 0; j < 8; j++) begin
      chk("rev_v", 256'(d_valid[0]), 256'(1'b1));
      chk("rev_d", d_data[63:0], 256'(wd(8'h02, 3'(j))));
      step();
    end
    chk("rev_drained", 256'(d_valid[0]), 256'(1'b0));

    // ch1 backpressure while ch0 streams
    tag_ready = 4'b0011; step(); tag_ready = '0;
    d_ready = 4'b0001;
    for (int i = 0; i < 8; i++) send(8'h10, 3'(i), wd(8'h10, 3'(i)));
    for (int i = 0; i < 8; i++) send(8'h03, 3'(i), wd(8'h03, 3'(i)));
    cnt0 = 0; cnt1 = 0; stall = 1'b0; held = '0;
    for (int c = 0; c < 60; c++) begin
      if (stall) begin
        chk("stall_hold_v", 256'(d_valid[1]), 256'(1'b1));
        chk("stall_hold_d", d_data[127:64], 256'(held));
      end
      r = ($urandom_range(0, 3) != 0);
      d_ready = {2'b00, r, 1'b1};
      #1;
      if (d_valid[0]) begin
        chk("bp_ch0_d", d_data[63:0], 256'(wd(8'h03, 3'(cnt0))));
        cnt0++;
      end
      if (d_valid[1] && r) begin
        chk("bp_ch1_d", d_data[127:64], 256'(wd(8'h10, 3'(cnt1))));
        cnt1++;
      end
      stall = d_valid[1] && !r;
      held  = d_data[127:64];
      step();
    end
    d_ready = 4'b1111;
    chk("bp_ch0_count", 256'(cnt0), 256'(8));
    chk("bp_ch1_count", 256'(cnt1), 256'(8));

    // drop handling; ch0 low 4 becomes the only outstanding tag
    tag_ready = 4'b0001; step(); tag_ready = '0;
`ifdef HIFIFO_RC_ERRCHK_EN
    send(8'h05, 3'd0, 64'hBAD0);
    chk("err_not_outstanding", 256'(rc_error), 256'(1'b1));
    send(8'h08, 3'd0, 64'hBAD1);
    chk("err_bit3", 256'(rc_error), 256'(1'b1));
    send(8'h24, 3'd0, 64'hBAD2);
    chk("err_disabled_ch", 256'(rc_error), 256'(1'b1));
    send(8'h04, 3'd0, wd(8'h04, 3'd0));
    chk("err_good_word", 256'(rc_error), 256'(1'b0));
    send(8'h04, 3'd0, 64'hBAD3);
    chk("err_duplicate", 256'(rc_error), 256'(1'b1));
`else
    send(8'h04, 3'd0, wd(8'h04, 3'd0));
    chk("noerr_good_word", 256'(rc_error), 256'(1'b0));
`endif
    for (int i = 1; i < 8; i++) send(8'h04, 3'(i), wd(8'h04, 3'(i)));
    chk("err_last_ok", 256'(rc_error), 256'(1'b0));
    step();
    for (int j = 0; j < 8; j++) begin
      chk("err_stream_v", 256'(d_valid), 256'(4'b0001));
      chk("err_stream_d", d_data[63:0], 256'(wd(8'h04, 3'(j))));
      step();
    end
    chk("err_drained", 256'(d_valid), 256'(4'b0000));

    // reset in the middle of a stream
    tag_ready = 4'b0001; step(); tag_ready = '0;
    for (int i = 0; i < 8; i++) send(8'h05, 3'(i), wd(8'h05, 3'(i)));
    step();
    chk("mid_v", 256'(d_valid[0]), 256'(1'b1));
    reset = 1'b1;
    step();
    chk("mid_rst_d_valid",   256'(d_valid),   256'(4'b0000));
    chk("mid_rst_d_data",    d_data,          256'h0);
    chk("mid_rst_tag_valid", 256'(tag_valid), 256'(4'b0000));
    reset = 1'b0;
    step();
    chk("mid_post_tag_valid", 256'(tag_valid), 256'(4'b0011));
    chk("mid_post_tag_low",   256'(tag_low),   256'(12'h000));
    for (int i = 0; i < 8; i++) begin
      send(8'h03, 3'(i), wd(8'h03, 3'(i)));
`ifdef HIFIFO_RC_ERRCHK_EN
      chk("stale_err", 256'(rc_error), 256'(1'b1));
`else
      chk("stale_noerr", 256'(rc_error), 256'(1'b0));
`endif
    end
    for (int j = 0; j < 3; j++) begin
      step();
      chk("stale_no_data", 256'(d_valid), 256'(4'b0000));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
